// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/issue stage and the controller:
// instruction layout, opcode values and the fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OPC_MSB = 11;
    localparam int unsigned OPC_LSB = 8;
    localparam int unsigned OPR_MSB = 7;
    localparam int unsigned OPR_LSB = 0;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADD_A = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUB_A = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_AND_A = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_OR_A  = 4'b0111;
    localparam logic [3:0] OP_SHR   = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } fetch_state_t;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [7:0] instr_operand(input logic [INSTR_W-1:0] word);
        return word[OPR_MSB:OPR_LSB];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: 2^ADDR_W x 12 words, synchronous write, registered read.
// The read register doubles as the fetch stage's instruction register.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [INSTR_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: steps a PC through program memory and
// presents one instruction every GAP+2 cycles to the controller.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned GAP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [11:0]       prog_data,
    output logic [3:0]        opcode,
    output logic [7:0]        operand,
    output logic              op,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    localparam int unsigned      GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [7:0]         operand_q, operand_d;

    logic [INSTR_W-1:0] ir;
    logic [3:0]         ir_opcode;
    logic [7:0]         ir_operand;
    logic               ir_halt;
    logic               accepting;
    logic               mem_we;
    logic               mem_re;
    logic               issuing;

    assign accepting  = (state_q == S_IDLE) || (state_q == S_HALT);
    assign mem_we     = prog_we && accepting;
    assign ir_opcode  = instr_opcode(ir);
    assign ir_operand = instr_operand(ir);
    assign ir_halt    = (ir_opcode == OP_HALT);

    prog_mem #(
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re),
        .raddr (pc_q),
        .rdata (ir)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        gap_d     = gap_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        mem_re    = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_re  = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (ir_halt) begin
                    state_d = S_HALT;
                end else begin
                    pc_d      = pc_q + ADDR_W'(1);
                    gap_d     = '0;
                    opcode_d  = ir_opcode;
                    operand_d = ir_operand;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            gap_q     <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            gap_q     <= gap_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    // The instruction register is the memory's read register, so the issuing
    // word is shown straight from it; the hold registers capture it at the end
    // of ISSUE and keep it until the next non-HALT issue.
    assign issuing = (state_q == S_ISSUE) && !ir_halt;
    assign opcode  = issuing ? ir_opcode  : opcode_q;
    assign operand = issuing ? ir_operand : operand_q;

    assign op     = issuing;
    assign pc     = pc_q;
    assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (default, ADDR_W=2, GAP=3)
// with a scoreboard of expected issues popped on each op strobe.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [2:0]  we_v;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;

    logic [3:0] opcode_a, opcode_b, opcode_c;
    logic [7:0] operand_a, operand_b, operand_c;
    logic       op_a, op_b, op_c;
    logic [3:0] pc_a, pc_c;
    logic [1:0] pc_b;
    logic       busy_a, busy_b, busy_c;
    logic       halted_a, halted_b, halted_c;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int         cyc;
        logic [3:0] opc;
        logic [7:0] opr;
        logic [3:0] pc;
    } exp_t;

    exp_t sb[$];

    logic       op_s, busy_s, halt_s;
    logic [3:0] opc_s, pc_s;
    logic [7:0] opr_s;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(4), .GAP(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .prog_we(we_v[0]),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode_a), .operand(operand_a), .op(op_a), .pc(pc_a),
        .busy(busy_a), .halted(halted_a)
    );

    fetch_unit #(.ADDR_W(2), .GAP(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .prog_we(we_v[1]),
        .prog_addr(prog_addr[1:0]), .prog_data(prog_data),
        .opcode(opcode_b), .operand(operand_b), .op(op_b), .pc(pc_b),
        .busy(busy_b), .halted(halted_b)
    );

    fetch_unit #(.ADDR_W(4), .GAP(3)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .prog_we(we_v[2]),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode_c), .operand(operand_c), .op(op_c), .pc(pc_c),
        .busy(busy_c), .halted(halted_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: begin
                op_s = op_a; opc_s = opcode_a; opr_s = operand_a;
                pc_s = pc_a; busy_s = busy_a; halt_s = halted_a;
            end
            1: begin
                op_s = op_b; opc_s = opcode_b; opr_s = operand_b;
                pc_s = {2'b00, pc_b}; busy_s = busy_b; halt_s = halted_b;
            end
            default: begin
                op_s = op_c; opc_s = opcode_c; opr_s = operand_c;
                pc_s = pc_c; busy_s = busy_c; halt_s = halted_c;
            end
        endcase
    endtask

    task automatic prog(input int sel, input logic [3:0] addr, input logic [3:0] opc,
                        input logic [7:0] opr);
        @(negedge clk);
        prog_addr    = addr;
        prog_data    = {opc, opr};
        we_v[sel]    = 1'b1;
        @(negedge clk);
        we_v         = '0;
    endtask

    task automatic push(input int cyc, input logic [3:0] opc, input logic [7:0] opr,
                        input logic [3:0] pc);
        exp_t e;
        e.cyc = cyc; e.opc = opc; e.opr = opr; e.pc = pc;
        sb.push_back(e);
    endtask

    // Pulses start (optionally with a same-cycle write), then watches ncyc
    // cycles counted from the start edge, popping the scoreboard on every op.
    task automatic run(input int sel, input int ncyc, input int halt_cyc,
                       input logic [3:0] halt_pc, input int inj_cyc,
                       input bit co_write, input logic [3:0] co_addr,
                       input logic [11:0] co_data);
        exp_t e;
        exp_t last;
        bit   have_last = 1'b0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        if (co_write) begin
            we_v[sel] = 1'b1;
            prog_addr = co_addr;
            prog_data = co_data;
        end
        @(posedge clk);
        #1;
        start_v = '0;
        we_v    = '0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            if (inj_cyc > 0 && cyc == inj_cyc + 1) begin
                start_v = '0;
                we_v    = '0;
            end
            sample(sel);
            if (cyc == 1) begin
                check("busy_after_start", busy_s, 1);
                check("halted_clear", halt_s, 0);
            end
            if (op_s === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_op", op_s, 0);
                end else begin
                    e = sb.pop_front();
                    check("op_cycle", cyc, e.cyc);
                    check("opcode", opc_s, e.opc);
                    check("operand", opr_s, e.opr);
                    check("pc_at_issue", pc_s, e.pc);
                    last      = e;
                    have_last = 1'b1;
                end
            end
            if (halt_cyc > 0 && cyc == halt_cyc - 1 && have_last) begin
                check("halt_issue_no_op", op_s, 0);
                check("held_opcode", opc_s, last.opc);
                check("held_operand", opr_s, last.opr);
            end
            if (halt_cyc > 0 && cyc >= halt_cyc) begin
                check("halted", halt_s, 1);
                check("busy_in_halt", busy_s, 0);
            end
            if (halt_cyc > 0 && cyc == halt_cyc) begin
                check("pc_in_halt", pc_s, halt_pc);
            end
            if (inj_cyc > 0 && cyc == inj_cyc) begin
                start_v[sel] = 1'b1;
                we_v[sel]    = 1'b1;
                prog_addr    = 4'd1;
                prog_data    = 12'h7AA;
            end
        end
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start_v   = '0;
        we_v      = '0;
        prog_addr = '0;
        prog_data = '0;
        #2;
        sample(0);
        check("rst_op", op_s, 0);
        check("rst_busy", busy_s, 0);
        check("rst_halted", halt_s, 0);
        check("rst_pc", pc_s, 0);
        check("rst_opcode", opc_s, 0);
        check("rst_operand", opr_s, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic issue
        prog(0, 4'd0, OP_ADD, 8'h05);
        prog(0, 4'd1, OP_SUB, 8'h03);
        prog(0, 4'd2, OP_SHR, 8'h00);
        prog(0, 4'd3, OP_HALT, 8'h00);
        push(2, OP_ADD, 8'h05, 4'd0);
        push(5, OP_SUB, 8'h03, 4'd1);
        push(8, OP_SHR, 8'h00, 4'd2);
        run(0, 14, 12, 4'd3, 0, 1'b0, 4'd0, 12'h000);

        // start and prog_we during WAIT must be ignored
        push(2, OP_ADD, 8'h05, 4'd0);
        push(5, OP_SUB, 8'h03, 4'd1);
        push(8, OP_SHR, 8'h00, 4'd2);
        run(0, 14, 12, 4'd3, 3, 1'b0, 4'd0, 12'h000);

        // Restart from HALT with a same-cycle rewrite of address 0
        sample(0);
        check("halted_before_restart", halt_s, 1);
        push(2, OP_OR_A, 8'h0F, 4'd0);
        push(5, OP_SUB, 8'h03, 4'd1);
        push(8, OP_SHR, 8'h00, 4'd2);
        run(0, 14, 12, 4'd3, 0, 1'b1, 4'd0, {OP_OR_A, 8'h0F});

        // Wrap-around with ADDR_W=2
        prog(1, 4'd0, OP_ADD, 8'h11);
        prog(1, 4'd1, OP_ADD_A, 8'h22);
        prog(1, 4'd2, OP_SUB, 8'h33);
        prog(1, 4'd3, OP_AND, 8'h44);
        push(2, OP_ADD, 8'h11, 4'd0);
        push(5, OP_ADD_A, 8'h22, 4'd1);
        push(8, OP_SUB, 8'h33, 4'd2);
        push(11, OP_AND, 8'h44, 4'd3);
        push(14, OP_ADD, 8'h11, 4'd0);
        run(1, 15, 0, 4'd0, 0, 1'b0, 4'd0, 12'h000);

        // GAP=3: issues 5 cycles apart
        prog(2, 4'd0, OP_ADD, 8'h01);
        prog(2, 4'd1, OP_SUB, 8'h02);
        prog(2, 4'd2, OP_AND, 8'h03);
        prog(2, 4'd3, OP_HALT, 8'h00);
        push(2, OP_ADD, 8'h01, 4'd0);
        push(7, OP_SUB, 8'h02, 4'd1);
        push(12, OP_AND, 8'h03, 4'd2);
        run(2, 20, 18, 4'd3, 0, 1'b0, 4'd0, 12'h000);

        // Async reset in the middle of an ISSUE cycle
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        @(negedge clk);
        @(negedge clk);
        sample(0);
        check("pre_reset_op", op_s, 1);
        check("pre_reset_opcode", opc_s, OP_OR_A);
        #2;
        reset = 1'b1;
        #1;
        sample(0);
        check("async_rst_op", op_s, 0);
        check("async_rst_busy", busy_s, 0);
        check("async_rst_halted", halt_s, 0);
        check("async_rst_pc", pc_s, 0);
        check("async_rst_opcode", opc_s, 0);
        check("async_rst_operand", opr_s, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample(0);
            check("post_rst_idle_busy", busy_s, 0);
            check("post_rst_idle_op", op_s, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
